dircc_node_mem_stream_writer: RTL

DIRCC_NODE_MEM_STREAM_WRITER -- requirements
Module: dircc_node_mem_stream_writer

---
 rtl/dircc_node_mem_stream_writer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dircc_node_mem_stream_writer.sv
// Streams one Avalon-ST packet into an on-chip RAM starting at base_addr,
// wrapping at MEM_DEPTH and truncating (with a sticky overflow flag) beyond max_words.
module dircc_node_mem_stream_writer #(
    parameter int ADDR_W    = 14,
    parameter int MEM_DEPTH = 10240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic [31:0]       snk_data,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_max;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_addr;
    logic              r_overflow;
    logic              w_write;
    logic              w_room;
    logic              w_accept_start;
    logic [ADDR_W:0]   w_base_ext;
    logic [ADDR_W-1:0] w_start_addr;

    assign w_room         = (r_index < r_max);
    assign w_accept_start = (r_state == S_IDLE) && start;
    assign w_base_ext     = {1'b0, base_addr};
    // base_addr may exceed the RAM; fold it once so the running address stays in range
    assign w_start_addr   = (w_base_ext >= DEPTH_EXT) ? ADDR_W'(w_base_ext - DEPTH_EXT) : base_addr;

    assign word_count = r_index;
    assign overflow   = r_overflow;
    assign mem_clken  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        snk_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        w_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (max_words == '0) ? S_DONE : S_ARMED;
            end
            S_ARMED: begin
                snk_ready = 1'b1;
                busy      = 1'b1;
                // Beats before the start of a packet are drained without writing
                if (snk_valid && snk_sop) begin
                    w_write = 1'b1;
                    w_next  = snk_eop ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                snk_ready = 1'b1;
                busy      = 1'b1;
                if (snk_valid) begin
                    w_write = w_room;
                    if (snk_eop) w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max          <= '0;
            r_index        <= '0;
            r_addr         <= '0;
            r_overflow     <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= 4'h0;
            mem_writedata  <= '0;
        end else begin
            mem_chipselect <= w_write;
            mem_write      <= w_write;
            if (w_accept_start) begin
                r_max      <= max_words;
                r_index    <= '0;
                r_addr     <= w_start_addr;
                r_overflow <= 1'b0;
            end
            if (w_write) begin
                mem_byteenable <= 4'hF;
                mem_writedata  <= snk_data;
                mem_address    <= r_addr;
                r_addr         <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_index        <= r_index + 1'b1;
            end
            if (r_state == S_WRITE && snk_valid && !w_room) r_overflow <= 1'b1;
        end
    end
endmodule
